// File: rtl/ones_count_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 127-bit popcount.
// Ports: reqN_valid/ready/data in, resp_valid/ready/id/count out, busy;
// with ONES_ACC_EN: acc_clr in, acc0/acc1 saturating ACC_W-bit totals.
module ones_count_arbiter
`ifdef ONES_ACC_EN
#(
  parameter int ACC_W = 16
)
`endif
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  input  logic [126:0] req0_data,
  input  logic [126:0] req1_data,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         resp_valid,
  output logic         resp_id,
  output logic [6:0]   resp_count,
  input  logic         resp_ready,
  output logic         busy
`ifdef ONES_ACC_EN
  ,
  input  logic         acc_clr,
  output logic [ACC_W-1:0] acc0,
  output logic [ACC_W-1:0] acc1
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COUNT,
    RESP
  } state_t;

  state_t       state_q, state_d;
  logic         last_q, last_d;
  logic         id_q, id_d;
  logic [126:0] opnd_q, opnd_d;
  logic [6:0]   cnt_q, cnt_d;

  logic grant_any;
  logic grant_id;

  function automatic logic [6:0] popcnt(input logic [126:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 127; i++) begin
      s = s + 7'(v[i]);
    end
    return s;
  endfunction

  // Tie goes to the requester not served last; a lone
  // requester wins regardless of history.
  assign grant_any = req0_valid | req1_valid;
  assign grant_id  = (req0_valid & req1_valid) ? ~last_q
                                               : req1_valid;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    id_d       = id_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          req0_ready = ~grant_id;
          req1_ready = grant_id;
          opnd_d     = grant_id ? req1_data : req0_data;
          id_d       = grant_id;
          last_d     = grant_id;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        state_d = COUNT;
      end
      COUNT: begin
        cnt_d   = popcnt(opnd_q);
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      opnd_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      opnd_q  <= opnd_d;
      cnt_q   <= cnt_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign resp_id    = id_q;
  assign resp_count = cnt_q;

`ifdef ONES_ACC_EN
  localparam int SW = ACC_W + 8;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [ACC_W-1:0] acc0_q, acc0_d;
  logic [ACC_W-1:0] acc1_q, acc1_d;
  logic [ACC_W-1:0] acc_sel;
  logic [ACC_W-1:0] acc_sat;
  logic [SW-1:0]    acc_sum;
  logic             resp_hs;

  assign resp_hs = resp_valid & resp_ready;
  assign acc_sel = id_q ? acc1_q : acc0_q;
  assign acc_sum = SW'(acc_sel) + SW'(cnt_q);
  assign acc_sat = (acc_sum > SW'(ACC_MAX)) ? ACC_MAX
                                            : acc_sum[ACC_W-1:0];

  always_comb begin
    acc0_d = acc0_q;
    acc1_d = acc1_q;
    if (acc_clr) begin
      acc0_d = '0;
      acc1_d = '0;
    end else if (resp_hs) begin
      if (id_q) begin
        acc1_d = acc_sat;
      end else begin
        acc0_d = acc_sat;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc0_q <= '0;
      acc1_q <= '0;
    end else begin
      acc0_q <= acc0_d;
      acc1_q <= acc1_d;
    end
  end

  assign acc0 = acc0_q;
  assign acc1 = acc1_q;
`endif

endmodule

// File: doc/ones_count_arbiter.md
ONES_COUNT_ARBITER -- requirements
Module: ones_count_arbiter

Interface
REQ-001 The block SHALL have parameter ACC_W, default 16, width of each per-requester ones accumulator (present only with ONES_ACC_EN).
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req0_valid, req1_valid  input  1 each  requester operand valid.
REQ-005 The block SHALL have ports req0_data, req1_data  input  127 each  operand whose set bits are counted.
REQ-006 The block SHALL have ports req0_ready, req1_ready  output  1 each  operand accepted this cycle when ANDed with valid.
REQ-007 The block SHALL have port resp_valid  output  1  result available.
REQ-008 The block SHALL have port resp_id  output  1  requester index owning the result.
REQ-009 The block SHALL have port resp_count  output  7  number of ones in the accepted operand, 0..127.
REQ-010 The block SHALL have port resp_ready  input  1  consumer accepts the result when ANDed with resp_valid.
REQ-011 The block SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 With ONES_ACC_EN, the block SHALL have ports acc_clr  input  1, acc0 and acc1  output  ACC_W each  running totals.

Function
REQ-013 The block SHALL implement FSM states IDLE, LOAD, COUNT, RESP with one shared combinational 127-bit ones-count datapath.
REQ-014 In IDLE, exactly one reqN_ready SHALL be high, for the arbitration winner among valid requesters; no ready is asserted when neither is valid.
REQ-015 Arbitration SHALL be round-robin: with both valid, grant the requester not served last; with one valid, grant it regardless of history.
REQ-016 On a request handshake, the operand and requester index SHALL be registered, the last-served pointer SHALL update, and the FSM SHALL go IDLE->LOAD.
REQ-017 LOAD->COUNT unconditionally; in COUNT the datapath output on the registered operand SHALL be registered into resp_count; COUNT->RESP unconditionally.
REQ-018 resp_valid SHALL be high exactly in RESP; resp_id, resp_count SHALL stay stable while resp_valid is high and resp_ready is low.
REQ-019 RESP->IDLE on resp_valid AND resp_ready; otherwise RESP holds indefinitely.
REQ-020 Latency: handshake at cycle n SHALL give resp_valid high at cycle n+3; throughput one operand per 4 cycles with resp_ready held high.
REQ-021 reqN_ready SHALL be low in LOAD, COUNT, RESP; operand changes on req*_data during those states SHALL not affect the result.
REQ-022 All-zero operand SHALL yield resp_count 0; all-ones operand SHALL yield 127 (no wrap).

Reset
REQ-023 rst_n low SHALL immediately force FSM to IDLE, resp_valid 0, resp_id 0, resp_count 0, busy 0, last-served pointer to 1 (requester 0 wins first tie).
REQ-024 Reset asserted mid-operation SHALL discard the in-flight operand without producing a response.
REQ-025 With ONES_ACC_EN, reset SHALL clear acc0 and acc1 to 0.

Configuration
REQ-026 Macro ONES_ACC_EN defined: on each response handshake accN for resp_id SHALL add resp_count, saturating at 2^ACC_W-1; acc_clr high SHALL synchronously zero both, winning over a same-cycle add.
REQ-027 Macro ONES_ACC_EN undefined: acc_clr, acc0, acc1 and ACC_W SHALL be absent; all other behaviour unchanged.

Verification
REQ-028 Reset, req0_valid=1 with data=127'h0F (4 ones) -> req0_ready high same cycle, resp_valid at +3 cycles, resp_id=0, resp_count=4.
REQ-029 Both valid continuously, resp_ready=1 -> grants alternate 0,1,0,1; first grant requester 0.
REQ-030 All-ones operand on req1, resp_ready held 0 for 10 cycles -> resp_valid stays high, resp_count=127, resp_id=1 stable; no new grant until resp_ready=1.
REQ-031 rst_n pulsed low in COUNT -> resp_valid never rises for that operand; busy=0; next tie grants requester 0.
REQ-032 ONES_ACC_EN, ACC_W=8: three req0 responses of 127 -> acc0=254 then saturates at 255; acc_clr with a simultaneous response handshake -> acc0=0.
